// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage to word-wide synchronous SRAM adapter.
// Accepts one byte/half/word load or store at a time. Each request becomes one
// or two aligned SRAM word accesses with byte enables and lane-shifted data.
// Load results are returned right-aligned and zero-extended.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   req_*                   MEM-stage request (valid/ready, addr, we, size, wdata)
//   resp_valid_o            one-cycle completion pulse
//   resp_rdata_o            last load result, held between loads
//   sram_*                  word SRAM port (req/gnt handshake, read data one cycle after grant)
module dmem_responder #(
    parameter int unsigned ADDR_W = 30
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_addr_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              sram_req_o,
    input  logic              sram_gnt_i,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [3:0]        sram_be_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_WAIT0,
        ST_ACC1,
        ST_WAIT1,
        ST_RESP
    } state_e;

    // 8-lane byte mask spanning both words of a possibly split access.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    // Right-align the addressed bytes of {second, first} and zero-extend to 32 bits.
    function automatic logic [31:0] extract(input logic [63:0] r64, input logic [1:0] size,
                                            input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = 32'(r64 >> {off, 3'b000});
        case (size)
            2'd0:    res = {24'd0, sh[7:0]};
            2'd1:    res = {16'd0, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_e              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         word0_q, word0_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic                req_ready_q, req_ready_d;
    logic                sram_req_q, sram_req_d;
    logic                sram_we_q, sram_we_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [3:0]          sram_be_q, sram_be_d;
    logic [31:0]         sram_wdata_q, sram_wdata_d;

    logic [3:0]          lanes_new;
    logic [31:0]         d_new;
    logic [7:0]          lanes_cur;
    logic [63:0]         d64_cur;
    logic                split_cur;
    logic [ADDR_W-1:0]   wi_cur;

    // Lane/data views of the incoming request and of the latched request.
    always_comb begin
        lanes_new = 4'(lane_mask(req_size_i, req_addr_i[1:0]));
        d_new     = req_wdata_i << {req_addr_i[1:0], 3'b000};
        lanes_cur = lane_mask(size_q, addr_q[1:0]);
        d64_cur   = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
        split_cur = (lanes_cur[7:4] != 4'd0);
        wi_cur    = ADDR_W'(addr_q[31:2]);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        word0_d      = word0_q;
        rdata_d      = rdata_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_be_d    = sram_be_q;
        sram_wdata_d = sram_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d       = req_addr_i;
                    we_d         = req_we_i;
                    size_d       = req_size_i;
                    wdata_d      = req_wdata_i;
                    sram_we_d    = req_we_i;
                    sram_addr_d  = ADDR_W'(req_addr_i[31:2]);
                    sram_be_d    = lanes_new;
                    sram_wdata_d = d_new;
                    state_d      = ST_ACC0;
                end
            end
            ST_ACC0: begin
                if (sram_gnt_i) begin
                    if (!we_q) begin
                        state_d = ST_WAIT0;
                    end else if (split_cur) begin
                        sram_addr_d  = wi_cur + ADDR_W'(1);
                        sram_be_d    = lanes_cur[7:4];
                        sram_wdata_d = d64_cur[63:32];
                        state_d      = ST_ACC1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT0: begin
                word0_d = sram_rdata_i;
                if (split_cur) begin
                    sram_addr_d  = wi_cur + ADDR_W'(1);
                    sram_be_d    = lanes_cur[7:4];
                    sram_wdata_d = d64_cur[63:32];
                    state_d      = ST_ACC1;
                end else begin
                    rdata_d = extract({32'd0, sram_rdata_i}, size_q, addr_q[1:0]);
                    state_d = ST_RESP;
                end
            end
            ST_ACC1: begin
                if (sram_gnt_i) begin
                    state_d = we_q ? ST_RESP : ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                rdata_d = extract({sram_rdata_i, word0_q}, size_q, addr_q[1:0]);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the state being entered.
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        sram_req_d   = (state_d == ST_ACC0) || (state_d == ST_ACC1);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'd0;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            wdata_q      <= 32'd0;
            word0_q      <= 32'd0;
            rdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_be_q    <= 4'd0;
            sram_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            word0_q      <= word0_d;
            rdata_q      <= rdata_d;
            resp_valid_q <= resp_valid_d;
            req_ready_q  <= req_ready_d;
            sram_req_q   <= sram_req_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_be_q    <= sram_be_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign sram_req_o   = sram_req_q;
    assign sram_we_o    = sram_we_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_be_o    = sram_be_q;
    assign sram_wdata_o = sram_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized traffic
// checked against a byte-addressed memory model and an access-count latency model.
module tb_dmem_responder;

    localparam int unsigned ADDR_W = 30;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_addr = 32'd0;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              sram_req;
    logic              sram_gnt;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [3:0]        sram_be;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata = 32'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_we_i     (req_we),
        .req_size_i   (req_size),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .sram_req_o   (sram_req),
        .sram_gnt_i   (sram_gnt),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_be_o    (sram_be),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    // ---------------- SRAM model (slots indexed by low word-address bits) ----------------
    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    logic [31:0] sram_mem [256] = '{default: 32'd0};
    acc_t        acc_log [64];
    int unsigned log_n = 0;
    int unsigned stalled = 0;
    int unsigned stall_target = 0;

    assign sram_gnt = (stalled >= stall_target);

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_req && sram_gnt) begin
            acc_log[log_n[5:0]] <= {sram_we, sram_addr, sram_be, sram_wdata};
            log_n <= log_n + 1;
            if (sram_we)
                sram_mem[sram_addr[7:0]] <= merge(sram_mem[sram_addr[7:0]], sram_wdata, sram_be);
            else
                sram_rdata <= sram_mem[sram_addr[7:0]];
            stalled <= 0;
        end else if (sram_req) begin
            stalled <= stalled + 1;
        end else begin
            stalled <= 0;
        end
    end

    // ---------------- Reference model: flat byte memory ----------------
    logic [7:0] ref_b [int unsigned];

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] ref_get(input int unsigned a);
        if (ref_b.exists(a)) return ref_b[a];
        return 8'h00;
    endfunction

    function automatic logic [31:0] ref_load(input int unsigned a, input logic [1:0] s);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < nbytes(s); i++)
            r = r | (32'(ref_get(a + 32'(i))) << (8 * i));
        return r;
    endfunction

    task automatic ref_store(input int unsigned a, input logic [1:0] s, input logic [31:0] d);
        for (int i = 0; i < nbytes(s); i++)
            ref_b[a + 32'(i)] = d[8*i +: 8];
    endtask

    // Accesses needed, each costing its grant cycle plus stalls, plus a read-data cycle for loads.
    function automatic int exp_lat(input int unsigned a, input logic [1:0] s, input logic w,
                                   input int unsigned stalls);
        int acc;
        acc = ((a % 4) + nbytes(s) > 4) ? 2 : 1;
        return 1 + acc * (1 + int'(stalls)) + (w ? 0 : acc);
    endfunction

    // ---------------- Transaction driver ----------------
    task automatic do_req(input logic [31:0] a, input logic w, input logic [1:0] s,
                          input logic [31:0] d, input int unsigned stalls,
                          output int lat, output logic [31:0] rdata);
        @(negedge clk);
        stall_target = stalls;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle: got %b want 1", req_ready);
        end
        req_valid = 1'b1; req_addr = a; req_we = w; req_size = s; req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_we    = 1'($urandom);
        req_size  = 2'($urandom);
        req_wdata = $urandom;
        lat = -1;
        for (int c = 1; c <= 80 && lat < 0; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_busy: cycle %0d got %b want 0", c, req_ready);
            end
            if (resp_valid === 1'b1) lat = c;
        end
        rdata = resp_rdata;
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL resp_timeout: addr %h no resp_valid within 80 cycles", a);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_pulse: resp_valid %b req_ready %b want 0 1", resp_valid, req_ready);
        end
        if (w) ref_store(a, s, d);
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 ||
            sram_req !== 1'b0 || sram_we !== 1'b0 || sram_be !== 4'd0 ||
            sram_addr !== '0 || sram_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: rdy %b rv %b rd %h req %b we %b be %h addr %h wd %h",
                     req_ready, resp_valid, resp_rdata, sram_req, sram_we, sram_be, sram_addr,
                     sram_wdata);
        end
    endtask

    task automatic test_aligned;
        int lat; logic [31:0] rd; int unsigned base; acc_t e;
        base = log_n;
        do_req(32'h100, 1'b1, 2'd2, 32'hDEADBEEF, 0, lat, rd);
        e = acc_log[base[5:0]];
        checks++;
        if (log_n - base != 1 || e !== {1'b1, 30'h40, 4'hF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL sw_access: n %0d got %h want %h", log_n - base, e,
                     {1'b1, 30'h40, 4'hF, 32'hDEADBEEF});
        end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
        do_req(32'h100, 1'b0, 2'd2, 32'h0, 0, lat, rd);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte;
        int lat; logic [31:0] rd; int unsigned base; acc_t e;
        base = log_n;
        do_req(32'h103, 1'b1, 2'd0, 32'h000000A5, 0, lat, rd);
        e = acc_log[base[5:0]];
        checks++;
        if (e.be !== 4'b1000 || e.wdata[31:24] !== 8'hA5 || e.addr !== 30'h40) begin
            errors++;
            $display("FAIL sb_access: be %b wdata %h addr %h want 1000 a5xxxxxx 40", e.be, e.wdata, e.addr);
        end
        do_req(32'h103, 1'b0, 2'd0, 32'h0, 0, lat, rd);
        checks++;
        if (rd !== 32'h000000A5) begin errors++; $display("FAIL lbu_data: got %h want 000000a5", rd); end
        do_req(32'h100, 1'b0, 2'd2, 32'h0, 0, lat, rd);
        checks++;
        if (rd !== 32'hA5ADBEEF) begin errors++; $display("FAIL lw_after_sb: got %h want a5adbeef", rd); end
    endtask

    task automatic test_split;
        int lat; logic [31:0] rd; logic [31:0] prev; int unsigned base; acc_t e0, e1;
        prev = resp_rdata;
        base = log_n;
        do_req(32'h102, 1'b1, 2'd2, 32'h11223344, 0, lat, rd);
        e0 = acc_log[base[5:0]];
        e1 = acc_log[5'(base + 1)];
        checks++;
        if (log_n - base != 2 || e0.addr !== 30'h40 || e0.be !== 4'b1100 || e0.wdata[31:16] !== 16'h3344 ||
            e1.addr !== 30'h41 || e1.be !== 4'b0011 || e1.wdata[15:0] !== 16'h1122 || !e0.we || !e1.we) begin
            errors++;
            $display("FAIL split_sw_access: n %0d e0 %h e1 %h", log_n - base, e0, e1);
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL split_sw_latency: got %0d want 3", lat); end
        checks++;
        if (rd !== prev) begin errors++; $display("FAIL store_keeps_rdata: got %h want %h", rd, prev); end
        do_req(32'h102, 1'b0, 2'd2, 32'h0, 0, lat, rd);
        checks++;
        if (rd !== 32'h11223344) begin errors++; $display("FAIL split_lw_data: got %h want 11223344", rd); end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL split_lw_latency: got %0d want 5", lat); end
    endtask

    task automatic test_split_half_wrap;
        int lat; logic [31:0] rd; int unsigned base; acc_t e0, e1;
        do_req(32'h107, 1'b1, 2'd0, 32'h000000AB, 0, lat, rd);
        do_req(32'h108, 1'b1, 2'd0, 32'h000000CD, 0, lat, rd);
        do_req(32'h107, 1'b0, 2'd1, 32'h0, 0, lat, rd);
        checks++;
        if (rd !== 32'h0000CDAB) begin errors++; $display("FAIL split_lh_data: got %h want 0000cdab", rd); end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL split_lh_latency: got %0d want 5", lat); end
        base = log_n;
        do_req(32'hFFFFFFFD, 1'b0, 2'd2, 32'h0, 0, lat, rd);
        e0 = acc_log[base[5:0]];
        e1 = acc_log[5'(base + 1)];
        checks++;
        if (e0.addr !== 30'h3FFFFFFF || e1.addr !== 30'h0 || e0.be !== 4'b1110 || e1.be !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_access: addr %h %h be %b %b want 3fffffff 0 1110 0001",
                     e0.addr, e1.addr, e0.be, e1.be);
        end
        checks++;
        if (rd !== ref_load(32'hFFFFFFFD, 2'd2)) begin
            errors++;
            $display("FAIL wrap_data: got %h want %h", rd, ref_load(32'hFFFFFFFD, 2'd2));
        end
    endtask

    task automatic test_stall;
        int lat; logic [31:0] rd; acc_t snap;
        @(negedge clk);
        stall_target = 3;
        req_valid = 1'b1; req_addr = 32'h100; req_we = 1'b0; req_size = 2'd2; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom); req_wdata = $urandom;
        lat = -1;
        snap = '0;
        for (int c = 1; c <= 80 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) snap = {sram_we, sram_addr, sram_be, sram_wdata};
            if (c <= 4) begin
                checks++;
                if (sram_req !== 1'b1 || {sram_we, sram_addr, sram_be, sram_wdata} !== snap ||
                    sram_gnt !== (c == 4)) begin
                    errors++;
                    $display("FAIL stall_hold: cycle %0d req %b gnt %b got %h want %h", c, sram_req,
                             sram_gnt, {sram_we, sram_addr, sram_be, sram_wdata}, snap);
                end
            end
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: cycle %0d got %b want 0", c, req_ready); end
            if (resp_valid === 1'b1) lat = c;
        end
        rd = resp_rdata;
        checks++;
        if (lat != 6) begin errors++; $display("FAIL stall_latency: got %0d want 6", lat); end
        checks++;
        if (rd !== ref_load(32'h100, 2'd2)) begin
            errors++;
            $display("FAIL stall_data: got %h want %h", rd, ref_load(32'h100, 2'd2));
        end
        stall_target = 0;
    endtask

    task automatic test_random;
        int lat; logic [31:0] rd; logic [31:0] prev; logic [31:0] a; logic [31:0] d;
        logic w; logic [1:0] s; int unsigned st;
        for (int i = 0; i < 40; i++) begin
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15)
                                              : 32'h200 + $urandom_range(0, 31);
            w  = 1'($urandom);
            s  = 2'($urandom);
            d  = $urandom;
            st = $urandom_range(0, 2);
            prev = resp_rdata;
            do_req(a, w, s, d, st, lat, rd);
            checks++;
            if (lat != exp_lat(a, s, w, st)) begin
                errors++;
                $display("FAIL rand_latency: addr %h we %b size %0d stalls %0d got %0d want %0d",
                         a, w, s, st, lat, exp_lat(a, s, w, st));
            end
            checks++;
            if (w ? (rd !== prev) : (rd !== ref_load(a, s))) begin
                errors++;
                $display("FAIL rand_rdata: addr %h we %b size %0d got %h want %h", a, w, s, rd,
                         w ? prev : ref_load(a, s));
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; bit seen;
        @(negedge clk);
        stall_target = 0;
        req_valid = 1'b1; req_addr = 32'h102; req_we = 1'b0; req_size = 2'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sram_req !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait0_state: req %b ready %b rv %b want 0 0 0", sram_req, req_ready, resp_valid);
        end
        reset_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_no_resp: got resp_valid after reset want none"); end
        do_req(32'h100, 1'b0, 2'd2, 32'h0, 0, lat, rd);
        checks++;
        if (rd !== ref_load(32'h100, 2'd2) || lat != 3) begin
            errors++;
            $display("FAIL post_reset_lw: got %h lat %0d want %h lat 3", rd, lat, ref_load(32'h100, 2'd2));
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        test_aligned();
        test_byte();
        test_split();
        test_split_half_wrap();
        test_stall();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
